// File: rtl/cpu_defs.sv
// Shared CPU definitions: load type codes, register/datapath widths and the
// load misalignment rule used by the writeback path.
package cpu_defs;

    localparam int unsigned XLEN  = 32;
    localparam int unsigned REG_W = 5;
    localparam int unsigned LDT_W = 3;

    localparam logic [LDT_W-1:0] LD_LW  = 3'd0;
    localparam logic [LDT_W-1:0] LD_LH  = 3'd1;
    localparam logic [LDT_W-1:0] LD_LHU = 3'd2;
    localparam logic [LDT_W-1:0] LD_LB  = 3'd3;
    localparam logic [LDT_W-1:0] LD_LBU = 3'd4;

    localparam logic [REG_W-1:0] REG_ZERO = 5'd0;

    // Word loads need a zero offset, halfword loads an even offset.
    function automatic logic load_misaligned(input logic [LDT_W-1:0] ld_type,
                                             input logic [1:0]       addr_lo);
        logic bad;
        bad = 1'b0;
        case (ld_type)
            LD_LW:         bad = (addr_lo != 2'd0);
            LD_LH, LD_LHU: bad = addr_lo[0];
            default:       bad = 1'b0;
        endcase
        return bad;
    endfunction

endpackage

// File: rtl/mem_wb_stage_if.sv
// MEM -> WB handoff bus: the retiring instruction presented by the MEM stage.
interface mem_wb_stage_if;
    import cpu_defs::*;

    logic             in_valid;
    logic             in_ready;
    logic             in_we;
    logic [REG_W-1:0] in_rd;
    logic             in_is_load;
    logic [LDT_W-1:0] in_ld_type;
    logic [1:0]       in_addr_lo;
    logic [XLEN-1:0]  in_alu_result;
    logic [XLEN-1:0]  in_mem_rdata;

    modport master (
        output in_valid, in_we, in_rd, in_is_load, in_ld_type, in_addr_lo,
               in_alu_result, in_mem_rdata,
        input  in_ready
    );

    modport slave (
        input  in_valid, in_we, in_rd, in_is_load, in_ld_type, in_addr_lo,
               in_alu_result, in_mem_rdata,
        output in_ready
    );

endinterface

// File: rtl/load_align.sv
// Writeback data select: passes ALU results, aligns and sign/zero-extends
// loaded bytes/halfwords, and flags misaligned loads. Purely combinational.
module load_align
    import cpu_defs::*;
(
    input  logic             is_load,
    input  logic [LDT_W-1:0] ld_type,
    input  logic [1:0]       addr_lo,
    input  logic [XLEN-1:0]  alu_result,
    input  logic [XLEN-1:0]  mem_rdata,
    output logic [XLEN-1:0]  data_c,
    output logic             misalign_c
);

    logic [15:0] half;
    logic [7:0]  byte_sel;

    always_comb begin
        half     = addr_lo[1] ? mem_rdata[31:16] : mem_rdata[15:0];
        byte_sel = mem_rdata[7:0];
        case (addr_lo)
            2'd0:    byte_sel = mem_rdata[7:0];
            2'd1:    byte_sel = mem_rdata[15:8];
            2'd2:    byte_sel = mem_rdata[23:16];
            default: byte_sel = mem_rdata[31:24];
        endcase
    end

    // Reserved load types write zero rather than stale or partial data.
    always_comb begin
        data_c     = alu_result;
        misalign_c = 1'b0;
        if (is_load) begin
            misalign_c = load_misaligned(ld_type, addr_lo);
            case (ld_type)
                LD_LW:   data_c = mem_rdata;
                LD_LH:   data_c = {{16{half[15]}}, half};
                LD_LHU:  data_c = {16'h0000, half};
                LD_LB:   data_c = {{24{byte_sel[7]}}, byte_sel};
                LD_LBU:  data_c = {24'h000000, byte_sel};
                default: data_c = '0;
            endcase
        end
    end

endmodule

// File: rtl/mem_wb_stage.sv
// MEM/WB pipeline stage feeding the register-file write port (written on
// negedge). Optional same-cycle forwarding compares under WB_BYPASS_EN.
module mem_wb_stage
    import cpu_defs::*;
#(
    parameter int unsigned CNT_W = 32
) (
    input  logic              CLK,
    input  logic              RST_N,
    mem_wb_stage_if.slave     mem,
    input  logic              flush,
    input  logic              hold,
`ifdef WB_BYPASS_EN
    input  logic [REG_W-1:0]  fwd_ra,
    input  logic [REG_W-1:0]  fwd_rb,
    output logic              fwd_a_hit,
    output logic              fwd_b_hit,
    output logic [XLEN-1:0]   fwd_data,
`endif
    output logic              WE,
    output logic [REG_W-1:0]  Rw,
    output logic [XLEN-1:0]   busW,
    output logic              misalign,
    output logic [CNT_W-1:0]  retired
);

    logic            valid_q;
    logic            written_q;
    logic            we_q;
    logic            accept;
    logic [XLEN-1:0] wb_data;
    logic            wb_misalign;

    load_align u_load_align (
        .is_load    (mem.in_is_load),
        .ld_type    (mem.in_ld_type),
        .addr_lo    (mem.in_addr_lo),
        .alu_result (mem.in_alu_result),
        .mem_rdata  (mem.in_mem_rdata),
        .data_c     (wb_data),
        .misalign_c (wb_misalign)
    );

    assign mem.in_ready = ~hold;
    assign accept       = mem.in_valid & ~hold & ~flush;

    // Rw doubles as the held destination register.
    assign WE = valid_q & we_q & (Rw != REG_ZERO) & ~written_q & ~hold;

    // written_q blocks a second negedge write if hold pauses a written entry.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            valid_q   <= 1'b0;
            written_q <= 1'b0;
            we_q      <= 1'b0;
            Rw        <= '0;
            busW      <= '0;
            misalign  <= 1'b0;
            retired   <= '0;
        end else if (accept) begin
            valid_q   <= 1'b1;
            written_q <= 1'b0;
            we_q      <= mem.in_we & ~wb_misalign;
            Rw        <= mem.in_rd;
            busW      <= wb_data;
            misalign  <= wb_misalign;
            if (!wb_misalign) begin
                retired <= retired + CNT_W'(1);
            end
        end else begin
            if (flush || !hold) begin
                valid_q <= 1'b0;
            end
            if (WE) begin
                written_q <= 1'b1;
            end
        end
    end

`ifdef WB_BYPASS_EN
    assign fwd_a_hit = WE & (fwd_ra == Rw);
    assign fwd_b_hit = WE & (fwd_rb == Rw);
    assign fwd_data  = busW;
`endif

endmodule

// File: tb/tb_mem_wb_stage.sv
// Directed bench for mem_wb_stage with a negedge register-file model.
module tb_mem_wb_stage;
    import cpu_defs::*;

    logic        CLK;
    logic        RST_N;
    logic        flush;
    logic        hold;
    logic        WE;
    logic [4:0]  Rw;
    logic [31:0] busW;
    logic        misalign;
    logic [31:0] retired;

    mem_wb_stage_if bus ();

    mem_wb_stage #(.CNT_W(32)) dut (
        .CLK      (CLK),
        .RST_N    (RST_N),
        .mem      (bus),
        .flush    (flush),
        .hold     (hold),
        .WE       (WE),
        .Rw       (Rw),
        .busW     (busW),
        .misalign (misalign),
        .retired  (retired)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    logic [31:0] rf [32];
    int          wr_cnt = 0;

    always @(negedge CLK) begin
        if (WE) begin
            rf[Rw] = busW;
            wr_cnt = wr_cnt + 1;
        end
    end

    int n_checks = 0;
    int n_pass   = 0;
    int w0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic present(input logic we, input logic [4:0] rd, input logic is_load,
                           input logic [2:0] ldt, input logic [1:0] alo,
                           input logic [31:0] alu, input logic [31:0] rdata);
        bus.in_valid      = 1'b1;
        bus.in_we         = we;
        bus.in_rd         = rd;
        bus.in_is_load    = is_load;
        bus.in_ld_type    = ldt;
        bus.in_addr_lo    = alo;
        bus.in_alu_result = alu;
        bus.in_mem_rdata  = rdata;
    endtask

    task automatic idle();
        bus.in_valid = 1'b0;
    endtask

    initial begin
        RST_N = 1'b0;
        flush = 1'b0;
        hold  = 1'b0;
        present(1'b0, 5'd0, 1'b0, 3'd0, 2'd0, 32'h0, 32'h0);
        idle();
        #12;
        check("rst_we", 32'(WE), 32'd0);
        check("rst_rw", 32'(Rw), 32'd0);
        check("rst_busw", busW, 32'h0);
        check("rst_misalign", 32'(misalign), 32'd0);
        check("rst_retired", retired, 32'd0);
        @(negedge CLK);
        RST_N = 1'b1;

        // ALU write to r5
        present(1'b1, 5'd5, 1'b0, 3'd0, 2'd0, 32'hDEADBEEF, 32'h0);
        tick();
        idle();
        check("alu_we", 32'(WE), 32'd1);
        check("alu_rw", 32'(Rw), 32'd5);
        check("alu_busw", busW, 32'hDEADBEEF);
        check("alu_retired", retired, 32'd1);
        @(negedge CLK);
        #1;
        check("rf_r5", rf[5], 32'hDEADBEEF);
        check("alu_one_write", 32'(wr_cnt), 32'd1);
        tick();
        check("alu_we_drop", 32'(WE), 32'd0);
        check("idle_rw_hold", 32'(Rw), 32'd5);
        check("idle_busw_hold", busW, 32'hDEADBEEF);

        // Load alignment and extension
        present(1'b1, 5'd6, 1'b1, LD_LB, 2'd3, 32'h0, 32'h80123456);
        tick();
        check("lb_busw", busW, 32'hFFFFFF80);
        check("lb_we", 32'(WE), 32'd1);
        present(1'b1, 5'd6, 1'b1, LD_LBU, 2'd3, 32'h0, 32'h80123456);
        tick();
        check("lbu_busw", busW, 32'h00000080);
        present(1'b1, 5'd6, 1'b1, LD_LHU, 2'd2, 32'h0, 32'hBEEF0000);
        tick();
        check("lhu_busw", busW, 32'h0000BEEF);
        present(1'b1, 5'd6, 1'b1, LD_LH, 2'd2, 32'h0, 32'hBEEF0000);
        tick();
        check("lh_busw", busW, 32'hFFFFBEEF);
        present(1'b1, 5'd6, 1'b1, LD_LB, 2'd1, 32'h0, 32'h0000_7F00);
        tick();
        check("lb_pos_busw", busW, 32'h0000007F);
        check("loads_retired", retired, 32'd6);

        // Write to r0 is suppressed but still retires
        present(1'b1, 5'd0, 1'b0, 3'd0, 2'd0, 32'h00001234, 32'h0);
        tick();
        idle();
        check("r0_we", 32'(WE), 32'd0);
        check("r0_retired", retired, 32'd7);
        check("r0_busw", busW, 32'h00001234);

        // Misaligned LW
        w0 = wr_cnt;
        present(1'b1, 5'd12, 1'b1, LD_LW, 2'd1, 32'h0, 32'hCAFEF00D);
        tick();
        idle();
        check("mis_flag", 32'(misalign), 32'd1);
        check("mis_we", 32'(WE), 32'd0);
        check("mis_retired", retired, 32'd7);
        tick();
        check("mis_sticky", 32'(misalign), 32'd1);
        check("mis_no_write", 32'(wr_cnt - w0), 32'd0);

        // Back-to-back accepts
        w0 = wr_cnt;
        present(1'b1, 5'd3, 1'b0, 3'd0, 2'd0, 32'h00000033, 32'h0);
        tick();
        present(1'b1, 5'd4, 1'b0, 3'd0, 2'd0, 32'h00000044, 32'h0);
        check("b2b_we3", 32'(WE), 32'd1);
        check("b2b_rw3", 32'(Rw), 32'd3);
        check("b2b_mis_clr", 32'(misalign), 32'd0);
        tick();
        idle();
        check("b2b_we4", 32'(WE), 32'd1);
        check("b2b_rw4", 32'(Rw), 32'd4);
        tick();
        check("b2b_we_off", 32'(WE), 32'd0);
        check("b2b_writes", 32'(wr_cnt - w0), 32'd2);
        check("rf_r3", rf[3], 32'h00000033);
        check("rf_r4", rf[4], 32'h00000044);

        // Hold for three cycles mid-entry
        present(1'b1, 5'd7, 1'b0, 3'd0, 2'd0, 32'h00000077, 32'h0);
        tick();
        idle();
        hold = 1'b1;
        w0 = wr_cnt;
        #1;
        check("hold_we", 32'(WE), 32'd0);
        check("hold_ready", 32'(bus.in_ready), 32'd0);
        tick();
        tick();
        tick();
        check("hold_we_still", 32'(WE), 32'd0);
        hold = 1'b0;
        #1;
        check("hold_release_we", 32'(WE), 32'd1);
        tick();
        check("hold_we_off", 32'(WE), 32'd0);
        check("hold_one_write", 32'(wr_cnt - w0), 32'd1);
        check("rf_r7", rf[7], 32'h00000077);
        check("hold_retired", retired, 32'd10);

        // Flush with in_valid: nothing captured
        present(1'b1, 5'd9, 1'b0, 3'd0, 2'd0, 32'h00000099, 32'h0);
        flush = 1'b1;
        tick();
        idle();
        flush = 1'b0;
        #1;
        check("flush_we", 32'(WE), 32'd0);
        check("flush_rw", 32'(Rw), 32'd7);
        check("flush_retired", retired, 32'd10);

        // Flush beats hold on a held entry
        present(1'b1, 5'd10, 1'b0, 3'd0, 2'd0, 32'h000000A0, 32'h0);
        tick();
        idle();
        flush = 1'b1;
        hold  = 1'b1;
        w0 = wr_cnt;
        tick();
        flush = 1'b0;
        hold  = 1'b0;
        #1;
        check("flush_hold_we", 32'(WE), 32'd0);
        tick();
        check("flush_hold_nowrite", 32'(wr_cnt - w0), 32'd0);
        check("flush_hold_retired", retired, 32'd11);

        // Reset mid-entry
        present(1'b1, 5'd11, 1'b0, 3'd0, 2'd0, 32'h000000B0, 32'h0);
        tick();
        idle();
        check("pre_rst_we", 32'(WE), 32'd1);
        #1;
        RST_N = 1'b0;
        #1;
        check("midrst_we", 32'(WE), 32'd0);
        check("midrst_retired", retired, 32'd0);
        check("midrst_rw", 32'(Rw), 32'd0);
        @(negedge CLK);
        RST_N = 1'b1;
        tick();
        check("post_rst_we", 32'(WE), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
